// File: rtl/sram_banked_bytemask_init_pkg.sv
// Shared types and helpers for the banked, byte-masked SRAM with zero-clear engine.
// Contents:
//   sram_state_e - clear-engine FSM states
//   lanes()      - number of 8-bit byte lanes in a word
//   bank_of()    - bank index of a word address (low address bits)
//   row_of()     - row index inside a bank (high address bits)
//   cfg_ok()     - legality of a parameter set, checked at elaboration
package sram_banked_bytemask_init_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } sram_state_e;

   function automatic int unsigned lanes(input int unsigned nbit);
      return nbit / 32'd8;
   endfunction

   // Banks are interleaved on the low address bits, so consecutive words hit
   // different banks.
   function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned nbanks);
      return addr % nbanks;
   endfunction

   function automatic logic [31:0] row_of(input logic [31:0] addr, input int unsigned nbanks);
      return addr / nbanks;
   endfunction

   function automatic bit cfg_ok(input int unsigned nword, input int unsigned nbit,
                                 input int unsigned nbanks, input int unsigned lat);
      return ((nbit % 32'd8) == 32'd0) && (nbit >= 32'd8) &&
             (nbanks >= 32'd1) && ((nbanks & (nbanks - 32'd1)) == 32'd0) &&
             ((nword % nbanks) == 32'd0) &&
             (lat >= 32'd1) && (lat <= 32'd3);
   endfunction

endpackage

// File: rtl/sram_banked_bytemask_init_if.sv
// Access bus of the banked SRAM.
//   master: CEB, WEB (active-low enables), BWEB (active-low byte mask), A, D, init_req
//   slave : Q (read data, held between reads), Q_valid (1-cycle pulse), busy (clear active)
interface sram_banked_bytemask_init_if
   import sram_banked_bytemask_init_pkg::*;
#(
   parameter int unsigned numWord = 2048,
   parameter int unsigned numBit  = 32
);
   localparam int unsigned AW = $clog2(numWord);
   localparam int unsigned NL = lanes(numBit);

   logic              CEB;
   logic              WEB;
   logic [NL-1:0]     BWEB;
   logic [AW-1:0]     A;
   logic [numBit-1:0] D;
   logic              init_req;
   logic [numBit-1:0] Q;
   logic              Q_valid;
   logic              busy;

   modport master (
      output CEB, WEB, BWEB, A, D, init_req,
      input  Q, Q_valid, busy
   );

   modport slave (
      input  CEB, WEB, BWEB, A, D, init_req,
      output Q, Q_valid, busy
   );
endinterface

// File: rtl/sram_banked_bytemask_init_bank.sv
// One SRAM bank: row-addressed array, byte-masked write, registered read.
// Ports:
//   CLK  - clock
//   we   - write this cycle (lanes with bweb[b]=0 are written)
//   re   - read this cycle (q updates on the next edge, holds otherwise)
//   row  - row address, bweb - active-low lane mask, d - write data, q - read data
// The array itself has no reset; the top clears it with its zero-clear engine.
module sram_banked_bytemask_init_bank
   import sram_banked_bytemask_init_pkg::*;
#(
   parameter int unsigned ROWS   = 512,
   parameter int unsigned numBit = 32,
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned NL    = lanes(numBit)
) (
   input  logic              CLK,
   input  logic              we,
   input  logic              re,
   input  logic [RW-1:0]     row,
   input  logic [NL-1:0]     bweb,
   input  logic [numBit-1:0] d,
   output logic [numBit-1:0] q
);
   logic [numBit-1:0] mem_q [ROWS];
   logic [numBit-1:0] rd_d;
   logic [numBit-1:0] rd_q;

   // Byte-masked array write
   always_ff @(posedge CLK) begin
      if (we) begin
         for (int b = 0; b < int'(NL); b++) begin
            if (!bweb[b]) begin
               mem_q[row][b*8 +: 8] <= d[b*8 +: 8];
            end
         end
      end
   end

   // Read register loads on a read and holds otherwise
   always_comb begin
      rd_d = rd_q;
      if (re) begin
         rd_d = mem_q[row];
      end else begin
         rd_d = rd_q;
      end
   end

   // Read data register
   always_ff @(posedge CLK) begin
      rd_q <= rd_d;
   end

   assign q = rd_q;
endmodule

// File: rtl/sram_banked_bytemask_init.sv
// Banked single-port SRAM with active-low byte mask, configurable read latency
// and a sequential zero-clear engine.
// Ports:
//   CLK   - clock, all state on the rising edge
//   reset - asynchronous, active-low
//   bus   - slave side of sram_banked_bytemask_init_if (CEB/WEB/BWEB/A/D/init_req in,
//           Q/Q_valid/busy out)
// After reset, and after init_req while idle, the engine writes zero to one row of
// every bank per cycle; accesses presented while busy are dropped.
module sram_banked_bytemask_init
   import sram_banked_bytemask_init_pkg::*;
#(
   parameter int unsigned numWord     = 2048,
   parameter int unsigned numBit      = 32,
   parameter int unsigned numBanks    = 4,
   parameter int unsigned readLatency = 1
) (
   input logic                          CLK,
   input logic                          reset,
   sram_banked_bytemask_init_if.slave   bus
);
   localparam int unsigned ROWS = numWord / numBanks;
   localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BW   = (numBanks > 1) ? $clog2(numBanks) : 1;
   localparam int unsigned NL   = lanes(numBit);

   if (!cfg_ok(numWord, numBit, numBanks, readLatency)) begin : g_cfg_bad
      $error("sram_banked_bytemask_init: illegal parameter combination");
   end

   sram_state_e       state_d, state_q;
   logic [RW-1:0]     ptr_d, ptr_q;
   logic              acc_s, in_range_s;
   logic [BW-1:0]     bank_sel_s;
   logic [RW-1:0]     row_s;
   logic [numBanks-1:0] bank_we_s, bank_re_s;
   logic [RW-1:0]     bank_row_s;
   logic [NL-1:0]     bank_bweb_s;
   logic [numBit-1:0] bank_d_s;
   logic [numBit-1:0] bank_q_s [numBanks];
   logic              vld0_d, vld0_q, oor0_d, oor0_q;
   logic [BW-1:0]     sel0_d, sel0_q;
   logic [numBit-1:0] rd_mux_s, fin_dat_s;
   logic              fin_vld_s;
   logic [numBit-1:0] q_d, q_q;
   logic              qv_d, qv_q;

   assign acc_s      = !bus.CEB && (state_q == ST_IDLE);
   assign in_range_s = (32'(bus.A) < numWord);
   assign bank_sel_s = BW'(bank_of(32'(bus.A), numBanks));
   assign row_s      = RW'(row_of(32'(bus.A), numBanks));

   // Clear-engine FSM: sweep every row once, then serve accesses
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_q == RW'(ROWS - 1)) begin
               state_d = ST_IDLE;
               ptr_d   = {RW{1'b0}};
            end else begin
               ptr_d   = ptr_q + RW'(1);
            end
         end
         ST_IDLE: begin
            if (bus.init_req) begin
               state_d = ST_CLEAR;
               ptr_d   = {RW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = {RW{1'b0}};
         end
      endcase
   end

   // Steer bank ports: clear writes all banks at once, accesses hit one bank
   always_comb begin
      bank_we_s   = {numBanks{1'b0}};
      bank_re_s   = {numBanks{1'b0}};
      bank_row_s  = row_s;
      bank_bweb_s = bus.BWEB;
      bank_d_s    = bus.D;
      if (state_q == ST_CLEAR) begin
         bank_we_s   = {numBanks{1'b1}};
         bank_row_s  = ptr_q;
         bank_bweb_s = {NL{1'b0}};
         bank_d_s    = {numBit{1'b0}};
      end else begin
         for (int b = 0; b < int'(numBanks); b++) begin
            bank_we_s[b] = acc_s && !bus.WEB && in_range_s && (bank_sel_s == BW'(b));
            bank_re_s[b] = acc_s &&  bus.WEB && in_range_s && (bank_sel_s == BW'(b));
         end
      end
   end

   for (genvar g = 0; g < int'(numBanks); g++) begin : g_bank
      sram_banked_bytemask_init_bank #(
         .ROWS   (ROWS),
         .numBit (numBit)
      ) u_bank (
         .CLK  (CLK),
         .we   (bank_we_s[g]),
         .re   (bank_re_s[g]),
         .row  (bank_row_s),
         .bweb (bank_bweb_s),
         .d    (bank_d_s),
         .q    (bank_q_s[g])
      );
   end

   // First read stage tracks which bank answers; out-of-range reads return zero
   always_comb begin
      vld0_d = acc_s && bus.WEB;
      sel0_d = sel0_q;
      oor0_d = oor0_q;
      if (vld0_d) begin
         sel0_d = bank_sel_s;
         oor0_d = !in_range_s;
      end else begin
         sel0_d = sel0_q;
         oor0_d = oor0_q;
      end
      if (oor0_q) begin
         rd_mux_s = {numBit{1'b0}};
      end else begin
         rd_mux_s = bank_q_s[sel0_q];
      end
   end

   if (readLatency == 1) begin : g_lat1
      assign fin_vld_s = vld0_q;
      assign fin_dat_s = rd_mux_s;
   end else begin : g_latn
      localparam int unsigned N = readLatency - 1;
      logic              vld_d [N];
      logic              vld_q [N];
      logic [numBit-1:0] dat_d [N];
      logic [numBit-1:0] dat_q [N];

      // Shift muxed read data and its valid through the extra latency stages
      always_comb begin
         vld_d[0] = vld0_q;
         dat_d[0] = rd_mux_s;
         for (int i = 1; i < int'(N); i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
      end

      // Extra latency stage registers; reset drops in-flight reads
      always_ff @(posedge CLK or negedge reset) begin
         if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
               vld_q[i] <= 1'b0;
               dat_q[i] <= {numBit{1'b0}};
            end
         end else begin
            for (int i = 0; i < int'(N); i++) begin
               vld_q[i] <= vld_d[i];
               dat_q[i] <= dat_d[i];
            end
         end
      end

      assign fin_vld_s = vld_q[N-1];
      assign fin_dat_s = dat_q[N-1];
   end

   // Output register: Q loads only when a read completes
   always_comb begin
      qv_d = fin_vld_s;
      if (fin_vld_s) begin
         q_d = fin_dat_s;
      end else begin
         q_d = q_q;
      end
   end

   // FSM, first read stage and output registers
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= {RW{1'b0}};
         vld0_q  <= 1'b0;
         sel0_q  <= {BW{1'b0}};
         oor0_q  <= 1'b0;
         q_q     <= {numBit{1'b0}};
         qv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         vld0_q  <= vld0_d;
         sel0_q  <= sel0_d;
         oor0_q  <= oor0_d;
         q_q     <= q_d;
         qv_q    <= qv_d;
      end
   end

   assign bus.Q       = q_q;
   assign bus.Q_valid = qv_q;
   assign bus.busy    = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_sram_banked_bytemask_init.sv
// Bench for sram_banked_bytemask_init: two instances (read latency 1 and 3) share one
// stimulus stream; a flat word-array model with a read-result queue per instance
// supplies every expected value.
module tb_sram_banked_bytemask_init;
   localparam int unsigned NW   = 2048;
   localparam int unsigned NB   = 32;
   localparam int unsigned NBK  = 4;
   localparam int unsigned ROWS = NW / NBK;

   logic CLK   = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   sram_banked_bytemask_init_if #(.numWord(NW), .numBit(NB)) bus1 ();
   sram_banked_bytemask_init_if #(.numWord(NW), .numBit(NB)) bus3 ();

   sram_banked_bytemask_init #(.numWord(NW), .numBit(NB), .numBanks(NBK), .readLatency(1))
      dut_l1 (.CLK(CLK), .reset(reset), .bus(bus1.slave));
   sram_banked_bytemask_init #(.numWord(NW), .numBit(NB), .numBanks(NBK), .readLatency(3))
      dut_l3 (.CLK(CLK), .reset(reset), .bus(bus3.slave));

   logic        ceb_i, web_i, init_i;
   logic [3:0]  bweb_i;
   logic [10:0] a_i;
   logic [31:0] d_i;

   assign bus1.CEB = ceb_i;  assign bus3.CEB = ceb_i;
   assign bus1.WEB = web_i;  assign bus3.WEB = web_i;
   assign bus1.BWEB = bweb_i; assign bus3.BWEB = bweb_i;
   assign bus1.A = a_i;      assign bus3.A = a_i;
   assign bus1.D = d_i;      assign bus3.D = d_i;
   assign bus1.init_req = init_i; assign bus3.init_req = init_i;

   typedef struct { int due; logic [31:0] data; } rd_t;
   logic [31:0] mm [NW];
   rd_t         q1[$], q3[$];
   logic [31:0] exp_q1, exp_q3;
   int          busy_left;
   int          edge_no = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_no);
   endtask

   task automatic model_reset();
      q1.delete();
      q3.delete();
      exp_q1 = 32'h0;
      exp_q3 = 32'h0;
      busy_left = ROWS;
      foreach (mm[i]) mm[i] = 32'h0;
   endtask

   task automatic check_outputs();
      logic v1, v3;
      v1 = 1'b0;
      v3 = 1'b0;
      if (q1.size() > 0 && q1[0].due == edge_no) begin
         v1 = 1'b1; exp_q1 = q1[0].data; void'(q1.pop_front());
      end
      if (q3.size() > 0 && q3[0].due == edge_no) begin
         v3 = 1'b1; exp_q3 = q3[0].data; void'(q3.pop_front());
      end
      check_val("l1_qvalid", {31'd0, bus1.Q_valid}, {31'd0, v1});
      check_val("l1_q", bus1.Q, exp_q1);
      check_val("l3_qvalid", {31'd0, bus3.Q_valid}, {31'd0, v3});
      check_val("l3_q", bus3.Q, exp_q3);
      check_val("l1_busy", {31'd0, bus1.busy}, {31'd0, (busy_left > 0)});
      check_val("l3_busy", {31'd0, bus3.busy}, {31'd0, (busy_left > 0)});
   endtask

   // One clock: apply the access rules at the rising edge, compare at the falling edge.
   task automatic cycle();
      logic [31:0] rd;
      @(posedge CLK);
      edge_no++;
      if (reset) begin
         if (busy_left > 0) begin
            busy_left--;
         end else begin
            if (!ceb_i && !web_i) begin
               for (int b = 0; b < 4; b++)
                  if (!bweb_i[b]) mm[a_i][b*8 +: 8] = d_i[b*8 +: 8];
            end
            if (!ceb_i && web_i) begin
               rd = (int'(a_i) < int'(NW)) ? mm[a_i] : 32'h0;
               q1.push_back('{due: edge_no + 1, data: rd});
               q3.push_back('{due: edge_no + 3, data: rd});
            end
            if (init_i) begin
               foreach (mm[i]) mm[i] = 32'h0;
               busy_left = ROWS;
            end
         end
      end
      @(negedge CLK);
      check_outputs();
   endtask

   task automatic set_idle();
      ceb_i = 1'b1; web_i = 1'b1; bweb_i = 4'hF; a_i = 11'd0; d_i = 32'h0; init_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] bw);
      ceb_i = 1'b0; web_i = 1'b0; a_i = a; d_i = d; bweb_i = bw; init_i = 1'b0;
      cycle();
      set_idle();
   endtask

   task automatic do_read(input logic [10:0] a);
      ceb_i = 1'b0; web_i = 1'b1; a_i = a; bweb_i = 4'($urandom); d_i = $urandom; init_i = 1'b0;
      cycle();
      set_idle();
   endtask

   task automatic do_init();
      set_idle();
      init_i = 1'b1;
      cycle();
      set_idle();
   endtask

   // Counts cycles with busy high (starting from already-seen cycles), bounded.
   task automatic count_busy(input int already);
      int n;
      int guard;
      n = already;
      guard = 0;
      while (bus1.busy && guard < 2000) begin
         n++; guard++;
         cycle();
      end
      check_val("busy_len", n, ROWS);
   endtask

   task automatic assert_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check_val("rst_l1_q", bus1.Q, 32'h0);
      check_val("rst_l1_qv", {31'd0, bus1.Q_valid}, 32'h0);
      check_val("rst_l3_q", bus3.Q, 32'h0);
      check_val("rst_l3_qv", {31'd0, bus3.Q_valid}, 32'h0);
      check_val("rst_busy", {31'd0, bus1.busy}, 32'h1);
      idle(3);
      reset = 1'b1;
   endtask

   initial begin
      set_idle();
      model_reset();
      #2 reset = 1'b0;
      #1 check_outputs();
      idle(2);
      reset = 1'b1;
      count_busy(0);

      // Cleared array reads zero
      do_read(11'd7);
      idle(1);
      check_val("t1_q7", bus1.Q, 32'h0);
      idle(3);

      // Full write then masked write
      do_write(11'd5, 32'hDEADBEEF, 4'b0000);
      do_read(11'd5);
      idle(1);
      check_val("t2_qv", {31'd0, bus1.Q_valid}, 32'h1);
      check_val("t2_q", bus1.Q, 32'hDEADBEEF);
      do_write(11'd5, 32'h11223344, 4'b1010);
      do_read(11'd5);
      idle(1);
      check_val("t3_q", bus1.Q, 32'hDE22BE44);
      do_write(11'd6, 32'hCAFEF00D, 4'b1111);
      do_read(11'd6);
      idle(3);

      // Back-to-back reads across all banks
      for (int i = 0; i < 4; i++) do_write(11'(i), 32'hA0000000 + 32'(i * 17), 4'b0000);
      for (int i = 0; i < 4; i++) do_read(11'(i));
      idle(5);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         ceb_i  = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
         web_i  = 1'($urandom);
         bweb_i = 4'($urandom);
         a_i    = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
         d_i    = $urandom;
         init_i = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
         cycle();
      end
      set_idle();
      while (busy_left > 0) cycle();

      // Clear request: write during busy is dropped
      do_write(11'd9, 32'h55AA55AA, 4'b0000);
      do_init();
      do_write(11'd9, 32'h12345678, 4'b0000);
      count_busy(1);
      do_read(11'd9);
      idle(1);
      check_val("t5_q9", bus1.Q, 32'h0);
      idle(3);

      // Reset part-way through a clear
      do_init();
      idle(100);
      assert_reset();
      count_busy(0);

      // Reset with two reads in flight on the latency-3 instance
      do_write(11'd1, 32'h01010101, 4'b0000);
      do_write(11'd2, 32'h02020202, 4'b0000);
      do_read(11'd1);
      do_read(11'd2);
      assert_reset();
      count_busy(0);
      do_read(11'd1);
      do_read(11'd2);
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
